// File: rtl/quadc_ctrl_pkg.sv
// Shared types for the quad ADC bring-up controller.
// State encoding is visible to software through the state register.
package quadc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DCM_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_IF_RST    = 3'd3,
    S_WAIT_SYNC = 3'd4,
    S_ALIGNED   = 3'd5,
    S_FAULT     = 3'd6
  } state_e;

  localparam int STATE_W   = 3;
  localparam int RETRY_W   = 3;
  localparam int CNT_W_DEF = 32;

  function automatic logic holds_dcm(state_e s);
    return s inside {S_IDLE, S_DCM_RST, S_FAULT};
  endfunction

  function automatic logic holds_if(state_e s);
    return !(s inside {S_WAIT_SYNC, S_ALIGNED});
  endfunction

endpackage

// File: rtl/quadc_bringup_ctrl_if.sv
// Control/status bundle between the register block,
// the bring-up controller and the ADC interface.
interface quadc_bringup_ctrl_if #(
  parameter int CNT_W = 32
);
  import quadc_ctrl_pkg::*;

  logic               enable;
  logic               force_resync;
  logic               valid_in;
  logic               sync_in;
  logic               dcm_reset;
  logic               if_reset;
  logic               aligned;
  logic               fault;
  logic [STATE_W-1:0] state;
  logic [RETRY_W-1:0] retry_cnt;
  logic [CNT_W-1:0]   sync_count;
  logic [CNT_W-1:0]   sync_err_count;

  modport master (
    input  enable, force_resync,
    input  valid_in, sync_in,
    output dcm_reset, if_reset,
    output aligned, fault, state, retry_cnt,
    output sync_count, sync_err_count
  );

  modport slave (
    output enable, force_resync,
    output valid_in, sync_in,
    input  dcm_reset, if_reset,
    input  aligned, fault, state, retry_cnt,
    input  sync_count, sync_err_count
  );

endinterface

// File: rtl/quadc_sync_det.sv
// Two-flop synchroniser; EDGE=1 returns a registered
// one-cycle rising-edge pulse instead of the level.
module quadc_sync_det #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1, s2, s3, p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
      p  <= s2 & ~s3;
    end
  end

  assign q = EDGE ? p : s2;

endmodule

// File: rtl/quadc_bringup_ctrl.sv
// Bring-up and health sequencer for the quad ADC
// interface: reset, lock, first sync, then monitor.
module quadc_bringup_ctrl
  import quadc_ctrl_pkg::*;
#(
  parameter int DCM_RST_CYCLES = 16,
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int MAX_RETRIES    = 7,
  parameter int SYNC_PERIOD    = 0,
  parameter int SYNC_TOL       = 2,
  parameter int CNT_W          = CNT_W_DEF
) (
  input logic                  user_clk,
  input logic                  reset_n,
  quadc_bringup_ctrl_if.master bus
);

  localparam int T_A =
    (TIMEOUT_CYCLES > SETTLE_CYCLES) ?
    TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int T_MAX =
    (T_A > DCM_RST_CYCLES) ? T_A : DCM_RST_CYCLES;
  localparam int TW = $clog2(T_MAX) + 1;

  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [TW-1:0] DCM_LAST =
    TW'(DCM_RST_CYCLES - 1);
  localparam logic [TW-1:0] SET_LAST =
    TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  localparam int LO_I =
    (SYNC_PERIOD > SYNC_TOL) ? SYNC_PERIOD - SYNC_TOL : 0;
  localparam logic [CNT_W-1:0] P_LO = CNT_W'(LO_I);
  localparam logic [CNT_W-1:0] P_SPAN =
    CNT_W'(SYNC_PERIOD + SYNC_TOL - LO_I);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  localparam logic [RETRY_W-1:0] MAX_R =
    RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] R_ONE = RETRY_W'(1);

  logic               valid_s, sync_p;
  state_e             st, nxt;
  logic               fail, restart;
  logic [TW-1:0]      tmr;
  logic [RETRY_W-1:0] retry;
  logic [CNT_W-1:0]   ptmr, elapsed;
  logic [CNT_W-1:0]   sync_cnt, err_cnt;
  logic               off_period;
  logic               dcm_q, ifr_q, al_q, flt_q;

  quadc_sync_det #(.EDGE(1'b0)) u_valid (
    .clk   (user_clk),
    .rst_n (reset_n),
    .d     (bus.valid_in),
    .q     (valid_s)
  );

  quadc_sync_det #(.EDGE(1'b1)) u_sync (
    .clk   (user_clk),
    .rst_n (reset_n),
    .d     (bus.sync_in),
    .q     (sync_p)
  );

  // elapsed counts cycles since the previous sync edge
  assign elapsed = (&ptmr) ? ptmr : ptmr + C_ONE;
  assign off_period = (SYNC_PERIOD != 0) &&
    ((elapsed - P_LO) > P_SPAN);

  always_comb begin
    nxt     = st;
    fail    = 1'b0;
    restart = 1'b0;
    if (!bus.enable) begin
      nxt = S_IDLE;
    end else if (bus.force_resync) begin
      nxt     = S_DCM_RST;
      restart = 1'b1;
    end else begin
      unique case (st)
        S_IDLE:
          nxt = S_DCM_RST;
        S_DCM_RST:
          if (tmr == DCM_LAST) nxt = S_WAIT_LOCK;
        S_WAIT_LOCK:
          if (valid_s) nxt = S_IF_RST;
          else if (tmr == TO_LAST) fail = 1'b1;
        S_IF_RST:
          if (!valid_s) fail = 1'b1;
          else if (tmr == SET_LAST) nxt = S_WAIT_SYNC;
        S_WAIT_SYNC:
          if (!valid_s) fail = 1'b1;
          else if (sync_p) nxt = S_ALIGNED;
          else if (tmr == TO_LAST) fail = 1'b1;
        S_ALIGNED:
          if (!valid_s) nxt = S_DCM_RST;
        S_FAULT:
          nxt = S_FAULT;
        default:
          nxt = S_IDLE;
      endcase
      if (fail)
        nxt = (retry == MAX_R) ? S_FAULT : S_DCM_RST;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!reset_n) begin
      st       <= S_IDLE;
      tmr      <= '0;
      retry    <= '0;
      ptmr     <= '0;
      sync_cnt <= '0;
      err_cnt  <= '0;
      dcm_q    <= 1'b1;
      ifr_q    <= 1'b1;
      al_q     <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      st    <= nxt;
      dcm_q <= holds_dcm(nxt);
      ifr_q <= holds_if(nxt);
      al_q  <= (nxt == S_ALIGNED);
      flt_q <= (nxt == S_FAULT);

      if (nxt != st || restart) tmr <= '0;
      else if (!(&tmr)) tmr <= tmr + T_ONE;

      if (restart)
        retry <= '0;
      else if (fail && retry != MAX_R)
        retry <= retry + R_ONE;
      else if (st == S_WAIT_SYNC && nxt == S_ALIGNED)
        retry <= '0;

      if (st != S_ALIGNED) begin
        ptmr <= '0;
      end else if (nxt == S_ALIGNED && sync_p) begin
        ptmr     <= '0;
        sync_cnt <= sync_cnt + C_ONE;
        if (off_period && !(&err_cnt))
          err_cnt <= err_cnt + C_ONE;
      end else begin
        ptmr <= elapsed;
      end
    end
  end

  assign bus.dcm_reset      = dcm_q;
  assign bus.if_reset       = ifr_q;
  assign bus.aligned        = al_q;
  assign bus.fault          = flt_q;
  assign bus.state          = st;
  assign bus.retry_cnt      = retry;
  assign bus.sync_count     = sync_cnt;
  assign bus.sync_err_count = err_cnt;

endmodule

// File: tb/tb_quadc_bringup_ctrl.sv
// Directed bench for quadc_bringup_ctrl: vector table
// plus hand sequences for the timing-sensitive cases.
module tb_quadc_bringup_ctrl;

  typedef struct {
    logic [3:0] in;
    int         cyc;
    logic [9:0] exp;
  } vec_t;

  logic user_clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t tbl [20];

  quadc_bringup_ctrl_if #(.CNT_W(32)) bus ();

  quadc_bringup_ctrl #(
    .DCM_RST_CYCLES (4),
    .SETTLE_CYCLES  (8),
    .TIMEOUT_CYCLES (64),
    .MAX_RETRIES    (2),
    .SYNC_PERIOD    (100),
    .SYNC_TOL       (2),
    .CNT_W          (32)
  ) dut (
    .user_clk (user_clk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 user_clk = ~user_clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic chk(input string name,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h",
               name, got, exp);
    end
  endtask

  // {state, dcm_reset, if_reset, aligned, fault, retry}
  function automatic logic [9:0] ctl();
    return {bus.state, bus.dcm_reset, bus.if_reset,
            bus.aligned, bus.fault, bus.retry_cnt};
  endfunction

  function automatic logic [63:0] cnts();
    return {bus.sync_count, bus.sync_err_count};
  endfunction

  function automatic vec_t v(input logic [3:0] in,
                             input int cyc,
                             input logic [9:0] exp);
    vec_t r;
    r.in  = in;
    r.cyc = cyc;
    r.exp = exp;
    return r;
  endfunction

  // sync rise d cycles after the previous rise
  task automatic pulse(input int d);
    tick(d - 4);
    bus.sync_in = 1'b1;
    tick(4);
    bus.sync_in = 1'b0;
  endtask

  int gaps [6] = '{100, 100, 100, 104, 98, 102};
  int errs [6] = '{0, 0, 0, 1, 1, 1};

  initial begin
    reset_n          = 1'b0;
    bus.enable       = 1'b1;
    bus.force_resync = 1'b0;
    bus.valid_in     = 1'b0;
    bus.sync_in      = 1'b0;

    // in = {enable, force, valid, sync}
    tbl[0]  = v(4'b1000,  3, {3'd1, 4'b1100, 3'd0});
    tbl[1]  = v(4'b1000,  1, {3'd2, 4'b0100, 3'd0});
    tbl[2]  = v(4'b1000, 63, {3'd2, 4'b0100, 3'd0});
    tbl[3]  = v(4'b1000,  1, {3'd1, 4'b1100, 3'd1});
    tbl[4]  = v(4'b1000,  4, {3'd2, 4'b0100, 3'd1});
    tbl[5]  = v(4'b1000, 63, {3'd2, 4'b0100, 3'd1});
    tbl[6]  = v(4'b1000,  1, {3'd1, 4'b1100, 3'd2});
    tbl[7]  = v(4'b1000,  4, {3'd2, 4'b0100, 3'd2});
    tbl[8]  = v(4'b1000, 64, {3'd6, 4'b1101, 3'd2});
    tbl[9]  = v(4'b1000, 20, {3'd6, 4'b1101, 3'd2});
    tbl[10] = v(4'b1100,  1, {3'd1, 4'b1100, 3'd0});
    tbl[11] = v(4'b1000,  3, {3'd1, 4'b1100, 3'd0});
    tbl[12] = v(4'b1000,  1, {3'd2, 4'b0100, 3'd0});
    tbl[13] = v(4'b0100,  1, {3'd0, 4'b1100, 3'd0});
    tbl[14] = v(4'b0000,  5, {3'd0, 4'b1100, 3'd0});
    tbl[15] = v(4'b1010,  1, {3'd1, 4'b1100, 3'd0});
    tbl[16] = v(4'b1010,  4, {3'd2, 4'b0100, 3'd0});
    tbl[17] = v(4'b1010,  1, {3'd3, 4'b0100, 3'd0});
    tbl[18] = v(4'b1010,  7, {3'd3, 4'b0100, 3'd0});
    tbl[19] = v(4'b1010,  1, {3'd4, 4'b0000, 3'd0});

    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("reset", {6'd0, ctl(), cnts()},
          {6'd0, 3'd0, 4'b1100, 3'd0, 64'd0});
    end

    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("dcm_len", {76'd0, bus.state, bus.dcm_reset},
          (k < 4) ? {76'd0, 3'd1, 1'b1}
                  : {76'd0, 3'd2, 1'b0});
    end

    tick(10);
    bus.valid_in = 1'b1;
    tick(2);
    chk("lock_wait", {70'd0, ctl()},
        {70'd0, 3'd2, 4'b0100, 3'd0});
    tick(1);
    chk("lock_seen", {70'd0, ctl()},
        {70'd0, 3'd3, 4'b0100, 3'd0});
    tick(7);
    chk("settle", {70'd0, ctl()},
        {70'd0, 3'd3, 4'b0100, 3'd0});
    tick(1);
    chk("wait_sync", {70'd0, ctl()},
        {70'd0, 3'd4, 4'b0000, 3'd0});
    tick(20);
    bus.sync_in = 1'b1;
    tick(3);
    chk("sync_lat", {70'd0, ctl()},
        {70'd0, 3'd4, 4'b0000, 3'd0});
    tick(1);
    chk("aligned", {6'd0, ctl(), cnts()},
        {6'd0, 3'd5, 4'b0010, 3'd0, 64'd0});
    bus.sync_in = 1'b0;

    for (int k = 0; k < 6; k++) begin
      pulse(gaps[k]);
      chk("period", {16'd0, cnts()},
          {16'd0, 32'(k + 1), 32'(errs[k])});
    end

    bus.valid_in = 1'b0;
    tick(2);
    chk("drop_lat", {70'd0, ctl()},
        {70'd0, 3'd5, 4'b0010, 3'd0});
    tick(1);
    chk("drop", {70'd0, ctl()},
        {70'd0, 3'd1, 4'b1100, 3'd0});

    for (int k = 0; k < 20; k++) begin
      {bus.enable, bus.force_resync,
       bus.valid_in, bus.sync_in} = tbl[k].in;
      tick(tbl[k].cyc);
      if (ctl() !== tbl[k].exp) begin
        miscompares++;
        $display("FAIL vec%0d: got %h want %h",
                 k, ctl(), tbl[k].exp);
      end
      vectors++;
    end

    reset_n = 1'b0;
    tick(1);
    chk("mid_reset", {6'd0, ctl(), cnts()},
        {6'd0, 3'd0, 4'b1100, 3'd0, 64'd0});
    reset_n = 1'b1;
    tick(1);
    chk("restart", {70'd0, ctl()},
        {70'd0, 3'd1, 4'b1100, 3'd0});

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
